// File: rtl/chime_pkg.sv
// Shared types and default tuning for the four-note chime (C5-E5-G5-C6 at 48 kHz).
package chime_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int HALF_C5 = 46;
  localparam int HALF_E5 = 36;
  localparam int HALF_G5 = 31;
  localparam int HALF_C6 = 23;

  localparam logic [31:0] DEF_AMPLITUDE    = 32'd10000000;
  localparam int          DEF_NOTE_SAMPLES = 12000;
  localparam int          DEF_GAP_SAMPLES  = 2400;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/chime_generator_square_osc.sv
// Square-wave phase tracker: steps only on advance, restarts positive on clear.
// Output is the sample for the post-update phase so the caller can register it directly.
module square_osc
  import chime_pkg::*;
#(
  parameter int                    SAMPLE_W  = 32,
  parameter logic [SAMPLE_W-1:0]   AMPLITUDE = SAMPLE_W'(DEF_AMPLITUDE),
  parameter int                    PH_W      = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                advance,
  input  logic                clear,
  input  logic [PH_W-1:0]     half_period,
  output logic [SAMPLE_W-1:0] sample_o
);

  localparam logic [SAMPLE_W-1:0] NEG_AMP = -AMPLITUDE;

  logic [PH_W-1:0] cnt_q, cnt_d;
  logic            neg_q, neg_d;

  always_comb begin
    cnt_d = cnt_q;
    neg_d = neg_q;
    if (clear) begin
      cnt_d = '0;
      neg_d = 1'b0;
    end else if (advance) begin
      if (cnt_q == half_period - PH_W'(1)) begin
        cnt_d = '0;
        neg_d = ~neg_q;
      end else begin
        cnt_d = cnt_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      neg_q <= neg_d;
    end
  end

  assign sample_o = neg_d ? NEG_AMP : AMPLITUDE;

endmodule

// File: rtl/chime_generator.sv
// Plays C5-E5-G5-C6 square-wave chime on start; one-cycle start latency, registered outputs.
// Sample held while write_ready is low; counters advance only on accepted transfers.
module chime_generator
  import chime_pkg::*;
#(
  parameter int                  SAMPLE_W     = 32,
  parameter logic [SAMPLE_W-1:0] AMPLITUDE    = SAMPLE_W'(DEF_AMPLITUDE),
  parameter int                  NOTE_SAMPLES = DEF_NOTE_SAMPLES,
  parameter int                  GAP_SAMPLES  = DEF_GAP_SAMPLES,
  parameter int                  HALF0        = HALF_C5,
  parameter int                  HALF1        = HALF_E5,
  parameter int                  HALF2        = HALF_G5,
  parameter int                  HALF3        = HALF_C6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                write_ready,
  output logic                write,
  output logic [SAMPLE_W-1:0] SDACL,
  output logic [SAMPLE_W-1:0] SDACR,
  output logic                busy,
  output logic                done
);

  localparam int MAX_HALF = max2(max2(HALF0, HALF1), max2(HALF2, HALF3));
  localparam int PH_W     = $clog2(MAX_HALF + 1);
  localparam int CNT_W    = max2($clog2(max2(NOTE_SAMPLES, GAP_SAMPLES)), 1);

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_SAMPLES - 1);

  state_e              state_q, state_d;
  logic [1:0]          note_q, note_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic                done_q, done_d;
  logic [SAMPLE_W-1:0] sdac_q, sdac_d;

  logic                xfer;
  logic                osc_adv, osc_clr;
  logic [PH_W-1:0]     half_sel;
  logic [SAMPLE_W-1:0] osc_sample;

  assign xfer = write_q & write_ready;

  always_comb begin
    case (note_q)
      2'd0:    half_sel = PH_W'(HALF0);
      2'd1:    half_sel = PH_W'(HALF1);
      2'd2:    half_sel = PH_W'(HALF2);
      default: half_sel = PH_W'(HALF3);
    endcase
  end

  square_osc #(
    .SAMPLE_W  (SAMPLE_W),
    .AMPLITUDE (AMPLITUDE),
    .PH_W      (PH_W)
  ) u_osc (
    .clk         (clk),
    .reset       (reset),
    .advance     (osc_adv),
    .clear       (osc_clr),
    .half_period (half_sel),
    .sample_o    (osc_sample)
  );

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    osc_adv = 1'b0;
    osc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TONE;
          note_d  = 2'd0;
          cnt_d   = '0;
          osc_clr = 1'b1;
        end
      end
      TONE: begin
        if (xfer) begin
          osc_adv = 1'b1;
          if (cnt_q == NOTE_LAST) begin
            cnt_d = '0;
            if (note_q == 2'd3) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (xfer) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = TONE;
            note_d  = note_q + 2'd1;
            osc_clr = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Oscillator output already reflects this cycle's advance/clear, so a stall re-selects the held sample.
    write_d = (state_d != IDLE);
    sdac_d  = (state_d == TONE) ? osc_sample : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      note_q  <= 2'd0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      sdac_q  <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      done_q  <= done_d;
      sdac_q  <= sdac_d;
    end
  end

  assign write = write_q;
  assign busy  = write_q;
  assign done  = done_q;
  assign SDACL = sdac_q;
  assign SDACR = sdac_q;

endmodule

// File: tb/tb_chime_generator.sv
// Directed bench for chime_generator with short notes and a hand-written sample table.
module tb_chime_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        write_ready;
  logic        write;
  logic [31:0] SDACL;
  logic [31:0] SDACR;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_seq [38];

  chime_generator #(
    .SAMPLE_W     (32),
    .AMPLITUDE    (32'd100),
    .NOTE_SAMPLES (8),
    .GAP_SAMPLES  (2),
    .HALF0        (4),
    .HALF1        (3),
    .HALF2        (2),
    .HALF3        (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .write_ready (write_ready),
    .write       (write),
    .SDACL       (SDACL),
    .SDACR       (SDACR),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, $signed(act), act, $signed(exp), exp);
  endtask

  // Starts a chime at the current negedge and tracks it until done (or the cycle budget expires).
  task automatic run_chime(input bit random_ready, input bit poke_start, output int done_cycle);
    int          idx;
    int          cyc;
    bit          stalled;
    bit          fin;
    logic [31:0] held;
    idx = 0; cyc = 0; stalled = 0; fin = 0; held = '0; done_cycle = -1;
    start = 1'b1;
    write_ready = 1'b1;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) begin
        fin = 1;
        done_cycle = cyc;
        check("xfer_count", idx, 38);
        check("done_write", {31'd0, write}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_sdacl", SDACL, 32'd0);
      end else begin
        check("busy_during", {31'd0, busy}, 32'd1);
        check("write_during", {31'd0, write}, 32'd1);
        check("lr_equal", SDACR, SDACL);
        if (stalled) check("stall_hold", SDACL, held);
        write_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (write_ready) begin
          if (idx < 38) check($sformatf("sample%0d", idx), SDACL, exp_seq[idx]);
          idx++;
          stalled = 0;
          if (poke_start && (idx == 5 || idx == 20)) start = 1'b1;
        end else begin
          stalled = 1;
          held = SDACL;
        end
      end
    end
    check("done_seen", {31'd0, fin}, 32'd1);
  endtask

  task automatic count_extra_done(input int cycles, output int extra);
    extra = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) extra++;
    end
  endtask

  initial begin
    int dc;
    int extra;
    exp_seq = '{
      100, 100, 100, 100, -100, -100, -100, -100, 0, 0,
      100, 100, 100, -100, -100, -100, 100, 100, 0, 0,
      100, 100, -100, -100, 100, 100, -100, -100, 0, 0,
      100, -100, 100, -100, 100, -100, 100, -100
    };

    reset = 1'b1; start = 1'b0; write_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sdacl", SDACL, 32'd0);
    check("rst_sdacr", SDACR, 32'd0);
    reset = 1'b0;

    // Idle quiet
    write_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i % 25 == 0) begin
        check("idle_write", {31'd0, write}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_sdacl", SDACL, 32'd0);
      end
    end

    // Basic chime
    run_chime(0, 0, dc);
    check("basic_done_cycle", dc, 39);
    @(negedge clk);
    check("done_falls", {31'd0, done}, 32'd0);
    count_extra_done(5, extra);
    check("basic_single_done", extra, 0);

    // Backpressure
    run_chime(1, 0, dc);
    count_extra_done(10, extra);
    check("bp_single_done", extra, 0);

    // Start while busy
    run_chime(0, 1, dc);
    check("busy_start_done_cycle", dc, 39);
    count_extra_done(10, extra);
    check("busy_start_single_done", extra, 0);

    // Back-to-back: start in the done cycle
    write_ready = 1'b1;
    run_chime(0, 0, dc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_write", {31'd0, write}, 32'd1);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_first", SDACL, 32'd100);

    // Run the second chime into the note-1 gap, then reset mid-chime
    repeat (18) @(negedge clk);
    check("gap_sdacl", SDACL, 32'd0);
    check("gap_write", {31'd0, write}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_write", {31'd0, write}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sdacl", SDACL, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    count_extra_done(40, extra);
    check("abort_no_done", extra, 0);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("replay_write", {31'd0, write}, 32'd1);
    check("replay_first", SDACL, 32'd100);
    check("replay_sdacr", SDACR, 32'd100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chime_generator.md
# chime_generator

Audio-output block for the home simulation. On a one-cycle `start` pulse (typically from the clap detector), it plays a fixed four-note rising chime (C5-E5-G5-C6) as square-wave samples. Samples go to the audio codec's DAC path through a valid/ready handshake. It is the transmit-side counterpart of the clap-detection receive path: identical samples drive left and right channels, and `done` pulses when the chime finishes.

## Interface
- `SAMPLE_W`, 32: sample width, two's complement.
- `AMPLITUDE`, 32'd10000000: square-wave peak magnitude; must be less than 2^(SAMPLE_W-1).
- `NOTE_SAMPLES`, 12000: accepted samples per note (0.25 s at 48 kHz).
- `GAP_SAMPLES`, 2400: accepted silent samples between notes (0.05 s).
- `HALF0`..`HALF3`, 46 / 36 / 31 / 23: half-period of each note, in samples.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle chime request; ignored while `busy`.
- `write_ready`  in  1  codec DAC path can accept a sample this cycle.
- `write`  out  1  sample valid.
- `SDACL`  out  SAMPLE_W  left-channel sample.
- `SDACR`  out  SAMPLE_W  right-channel sample; always equal to `SDACL`.
- `busy`  out  1  chime in progress.
- `done`  out  1  one-cycle pulse after the final sample transfers.

## Operation
- **States:** IDLE, TONE, GAP. The note index `note` is 2 bits.
- **IDLE:**
  - `start`=1 → TONE with `note`=0, sample counter=0, phase counter=0, phase=positive.
  - `start` while TONE or GAP has no effect.
- **Transfer:** a transfer occurs in any cycle where `write` && `write_ready`. All counters advance only on a transfer.
- **TONE, per transfer:**
  - Output is +AMPLITUDE when phase is positive, −AMPLITUDE (two's complement) when negative.
  - The phase counter increments. When it reaches HALF[note]−1 it wraps to 0 and the phase toggles.
  - The sample counter increments. At NOTE_SAMPLES−1:
    - `note`<3: go to GAP, sample counter=0.
    - `note`=3: go to IDLE.
- **GAP:**
  - Output is 0.
  - After GAP_SAMPLES transfers: go to TONE, `note`+1, phase counter=0, phase=positive.
- **Handshake:**
  - `write`=1 throughout TONE and GAP, regardless of `write_ready`.
  - While `write`=1 and `write_ready`=0, `SDACL`/`SDACR` hold their value.
  - `write_ready` may toggle in any cycle. Samples are never dropped or duplicated.
- **Outputs:**
  - `busy`=1 exactly when the state is not IDLE.
  - `done` is asserted in the single cycle that follows the last TONE transfer of note 3.
- **Reset:**
  - `reset` asserted at any time, including mid-chime, forces IDLE immediately.
  - All counters clear. `write`=0, `SDACL`=`SDACR`=0, `busy`=0, `done`=0.
  - No `done` is produced for an aborted chime.
- **Counter widths:** sized from the parameters with $clog2.

## Timing
- All outputs are registered. `write`, `SDACL`, `SDACR`, `busy` and `done` change only on a clock edge (or asynchronously on `reset`).
- Start latency: `start` sampled high at edge N → `write`=1, `busy`=1, `SDACL`=+AMPLITUDE after edge N.
- Sample update: a transfer at edge M presents the next sample after edge M. Zero bubble cycles when `write_ready` stays high.
- State boundaries:
  - Last GAP transfer at edge M → first sample of the next note is valid after edge M.
  - Last note-3 transfer at edge M → after edge M: `write`=0, `busy`=0, `done`=1, `SDACL`=0. `done` falls after edge M+1.
- `start` in the same cycle as `done` is accepted, because the state is already IDLE.
- Ideal duration with `write_ready` held high: 4·NOTE_SAMPLES + 3·GAP_SAMPLES cycles from the first `write` to the cycle before `done`.

## Structure
- Package `chime_pkg` holds:
  - the state enum (IDLE, TONE, GAP);
  - the default half-period constants for C5/E5/G5/C6 at 48 kHz;
  - the default AMPLITUDE, NOTE_SAMPLES and GAP_SAMPLES constants.
- One sub-module, `square_osc`: phase counter plus phase flip-flop, taking inputs `advance`, `clear`, `half_period` and producing the ±AMPLITUDE sample. The top level owns the FSM, the sample/note counters, the handshake and the output registers.

## Test plan
All scenarios use NOTE_SAMPLES=8, GAP_SAMPLES=2, HALF0..3=4,3,2,1, AMPLITUDE=100.
- **Basic chime:** `write_ready`=1 constantly; `start` pulse.
  - Note 0: +100×4, −100×4, then 0,0.
  - Note 1: +100×3, −100×3, +100×2, then 0,0.
  - Note 2: (+100,+100,−100,−100)×2, then 0,0.
  - Note 3: alternating +100/−100 ×8.
  - `done` in cycle 39 after `start`, total 38 transfers; `SDACR`==`SDACL` throughout.
- **Backpressure:** `write_ready` random at 50% duty.
  - Same 38-sample sequence in order, with data stable across every stall.
  - `done` exactly once.
- **Start while busy:** `start` pulsed at transfer 5 and transfer 20 → ignored; sequence unchanged, single `done`.
- **Mid-chime reset:** reset asserted during the note-1 GAP.
  - Immediately `write`=0, `busy`=0, `SDACL`=0; no `done`.
  - A new `start` replays from note 0 at +100.
- **Back-to-back chimes:** `start` in the `done` cycle → second chime begins next cycle with +100.
- **Idle quiet:** `write_ready`=1 with no `start` for 100 cycles → `write`=0, `SDACL`=0, `busy`=0.
